// File: rtl/bcd_display_ctrl_if.sv
// Handshake and display-digit bundle between a result source and bcd_display_ctrl.
// master = value producer / display consumer, slave = the controller.
interface bcd_display_ctrl_if #(
    parameter int IN_WIDTH = 14
);
    logic [IN_WIDTH-1:0] in_value;
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          number_0;
    logic [3:0]          number_1;
    logic [3:0]          number_2;
    logic [3:0]          number_3;
    logic                busy;
    logic                update_done;
    logic                overflow;

    modport master (
        output in_value, in_valid,
        input  in_ready, number_0, number_1, number_2, number_3,
        input  busy, update_done, overflow
    );

    modport slave (
        input  in_value, in_valid,
        output in_ready, number_0, number_1, number_2, number_3,
        output busy, update_done, overflow
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD sequencing controller for the 4-digit display multiplexer (serial double-dabble).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits at non-overflow commits.
module bcd_display_ctrl #(
    parameter int          IN_WIDTH   = 14,
    parameter logic [3:0]  BLANK_CODE = 4'hF,
    parameter logic [3:0]  ERR_CODE   = 4'hE
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_display_ctrl_if.slave     bus
);

    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    // Add 3 to every nibble that is 5 or more; nibbles never carry into each other.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
        logic [15:0] res;
        res = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = acc[i*4 +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [15:0] commit_digits(input logic [15:0] acc, input logic ovf);
        logic [15:0] res;
        logic        lead;
        res  = acc;
        lead = 1'b1;
        if (ovf) begin
            res = {ERR_CODE, BLANK_CODE, BLANK_CODE, BLANK_CODE};
        end else begin
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 3; i >= 1; i--) begin
                if (lead && (acc[i*4 +: 4] == 4'd0)) begin
                    res[i*4 +: 4] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
`else
            res = acc;
`endif
        end
        return res;
    endfunction

    state_e               state_q, state_d;
    logic [IN_WIDTH-1:0]  sr_q, sr_d;
    logic [15:0]          acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [15:0]          digits_q, digits_d;
    logic                 overflow_q, overflow_d;
    logic                 update_done_q, update_done_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        ovf_pend_d    = ovf_pend_q;
        digits_d      = digits_q;
        overflow_d    = overflow_q;
        update_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sr_d       = bus.in_value;
                    acc_d      = 16'd0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(bus.in_value) > 32'd9999);
                    state_d    = CONVERT;
                end else begin
                    state_d    = IDLE;
                end
            end
            CONVERT: begin
                // MSBs leaving the 16-bit accumulator are dropped; only happens for overflow values.
                {acc_d, sr_d} = {dabble_adjust(acc_q), sr_q} << 1;
                cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end else begin
                    state_d = CONVERT;
                end
            end
            COMMIT: begin
                digits_d      = commit_digits(acc_q, ovf_pend_q);
                overflow_d    = ovf_pend_q;
                update_done_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            acc_q         <= 16'd0;
            cnt_q         <= '0;
            ovf_pend_q    <= 1'b0;
            digits_q      <= 16'd0;
            overflow_q    <= 1'b0;
            update_done_q <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            ovf_pend_q    <= ovf_pend_d;
            digits_q      <= digits_d;
            overflow_q    <= overflow_d;
            update_done_q <= update_done_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.number_3    = digits_q[15:12];
    assign bus.number_2    = digits_q[11:8];
    assign bus.number_1    = digits_q[7:4];
    assign bus.number_0    = digits_q[3:0];
    assign bus.overflow    = overflow_q;
    assign bus.update_done = update_done_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed self-checking bench for bcd_display_ctrl (digits, latency, overflow, reset abort).
module tb_bcd_display_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_display_ctrl_if #(.IN_WIDTH(14)) bus ();

    bcd_display_ctrl #(
        .IN_WIDTH   (14),
        .BLANK_CODE (4'hF),
        .ERR_CODE   (4'hE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.number_3, bus.number_2, bus.number_1, bus.number_0};
    endfunction

    // Drive one request from a negedge; returns edges from accept to update_done and a count of
    // cycles in which busy/in_ready/held digits were wrong during the conversion. lat = -1 on no accept.
    task automatic send(input logic [13:0] v, output int lat, output int viol);
        int          w;
        logic [15:0] prev;
        viol = 0;
        lat  = 0;
        bus.in_value = v;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            lat = -1;
            bus.in_valid = 1'b0;
        end else begin
            prev = digits();
            @(posedge clk);
            while (lat < 40) begin
                @(negedge clk);
                if (lat == 0) bus.in_valid = 1'b0;
                if (bus.update_done === 1'b1) break;
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || digits() !== prev) viol++;
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_value = 14'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (digits() !== 16'h0000) begin
            errors++; $display("FAIL reset_digits: got %h expected 0000", digits());
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ready=%b busy=%b ovf=%b expected 1 0 0",
                                bus.in_ready, bus.busy, bus.overflow);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.update_done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_idle_no_done: got %0d pulses expected 0", seen);
        end
    endtask

    task automatic test_convert();
        int lat, viol;
        send(14'd1234, lat, viol);
        checks++;
        if (lat != 15) begin errors++; $display("FAIL conv_latency: got %0d expected 15", lat); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL conv_busy_hold: got %0d bad cycles expected 0", viol); end
        checks++;
        if (digits() !== 16'h1234) begin errors++; $display("FAIL conv_digits: got %h expected 1234", digits()); end
        checks++;
        if (bus.overflow !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL conv_flags: ovf=%b ready=%b busy=%b expected 0 1 0",
                                bus.overflow, bus.in_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.update_done !== 1'b0) begin errors++; $display("FAIL conv_pulse_width: got %b expected 0", bus.update_done); end
    endtask

    task automatic test_back_to_back();
        int lat, viol;
        logic [15:0] exp0, exp42;
`ifdef LEADING_ZERO_BLANK_EN
        exp0  = 16'hFFF0;
        exp42 = 16'hFF42;
`else
        exp0  = 16'h0000;
        exp42 = 16'h0042;
`endif
        send(14'd9999, lat, viol);
        checks++;
        if (lat != 15 || viol != 0 || digits() !== 16'h9999) begin
            errors++; $display("FAIL b2b_9999: lat=%0d viol=%0d digits=%h expected 15 0 9999", lat, viol, digits());
        end
        send(14'd0, lat, viol);
        checks++;
        if (lat != 15 || viol != 0 || digits() !== exp0) begin
            errors++; $display("FAIL b2b_0: lat=%0d viol=%0d digits=%h expected 15 0 %h", lat, viol, digits(), exp0);
        end
        send(14'd42, lat, viol);
        checks++;
        if (lat != 15 || viol != 0 || digits() !== exp42) begin
            errors++; $display("FAIL b2b_42: lat=%0d viol=%0d digits=%h expected 15 0 %h", lat, viol, digits(), exp42);
        end
    endtask

    task automatic test_overflow();
        int lat, viol;
        logic [15:0] exp7;
`ifdef LEADING_ZERO_BLANK_EN
        exp7 = 16'hFFF7;
`else
        exp7 = 16'h0007;
`endif
        send(14'd10000, lat, viol);
        checks++;
        if (lat != 15 || digits() !== 16'hEFFF || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_10000: lat=%0d digits=%h ovf=%b expected 15 efff 1", lat, digits(), bus.overflow);
        end
        send(14'd16383, lat, viol);
        checks++;
        if (lat != 15 || digits() !== 16'hEFFF || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_16383: lat=%0d digits=%h ovf=%b expected 15 efff 1", lat, digits(), bus.overflow);
        end
        send(14'd7, lat, viol);
        checks++;
        if (lat != 15 || digits() !== exp7 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear_7: lat=%0d digits=%h ovf=%b expected 15 %h 0", lat, digits(), bus.overflow, exp7);
        end
    endtask

    task automatic test_ignore_during_convert();
        int lat, bad;
        logic [15:0] exp321, exp999;
`ifdef LEADING_ZERO_BLANK_EN
        exp321 = 16'hF321;
        exp999 = 16'hF999;
`else
        exp321 = 16'h0321;
        exp999 = 16'h0999;
`endif
        bus.in_value = 14'd321;
        bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ign_ready_idle: got %b expected 1", bus.in_ready); end
        @(posedge clk);
        lat = 0;
        bad = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (bus.update_done === 1'b1) break;
            if (bus.in_ready !== 1'b0) bad++;
            bus.in_value = lat[0] ? 14'd1111 : 14'd8765;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat != 15 || bad != 0 || digits() !== exp321) begin
            errors++; $display("FAIL ign_first: lat=%0d bad=%0d digits=%h expected 15 0 %h", lat, bad, digits(), exp321);
        end
        bus.in_value = 14'd999;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (lat == 0) bus.in_valid = 1'b0;
            if (bus.update_done === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat != 15 || digits() !== exp999) begin
            errors++; $display("FAIL ign_second: lat=%0d digits=%h expected 15 %h", lat, digits(), exp999);
        end
    endtask

    task automatic test_reset_mid_convert();
        int lat, viol, seen;
        bus.in_value = 14'd5678;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (digits() !== 16'h0000 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state: digits=%h busy=%b ready=%b ovf=%b expected 0000 0 1 0",
                                digits(), bus.busy, bus.in_ready, bus.overflow);
        end
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.update_done !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", seen); end
        send(14'd5678, lat, viol);
        checks++;
        if (lat != 15 || viol != 0 || digits() !== 16'h5678) begin
            errors++; $display("FAIL rst_mid_retry: lat=%0d viol=%0d digits=%h expected 15 0 5678", lat, viol, digits());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_value = 14'd0;
        @(negedge clk);
        test_reset();
        test_convert();
        test_back_to_back();
        test_overflow();
        test_ignore_during_convert();
        test_reset_mid_convert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
